// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and parameter checks for the two-port-RAM
// FIFO controller (fifo_tp_ctrl) and its pointer sub-module (fifo_ptr).
//   ptr_width(depth)   : RAM address width
//   cnt_width(depth)   : width of a 0..depth entry counter
//   level_width(depth) : width of the 0..depth+1 status level
//   is_pow2(depth)     : legal-depth check, evaluated at elaboration
package fifo_pkg;

    localparam int MIN_DEPTH = 2;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer with enable and synchronous active-high reset.
// Wraps silently from 2**WIDTH-1 to 0.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous reset, clears the pointer
//   i_en   : advance by one this cycle
//   o_ptr  : current pointer value
module fifo_ptr #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_tp_ctrl.sv
// fifo_tp_ctrl: synchronous FIFO controller driving an external two-port RAM
// with one-cycle registered read data. Upstream valid/ready push port,
// downstream first-word-fall-through valid/ready pop port. Capacity is
// DEPTH+1 (DEPTH in the RAM plus one word held in the RAM output register).
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data : push port
//   m_valid/m_ready/m_data : pop port, m_data comes straight from ram_rdata
//   ram_cen/ram_wen/ram_waddr/ram_wdata : RAM write side (+ combined enable)
//   ram_ren/ram_raddr/ram_rdata         : RAM read side
// Optional feature macro FIFO_TP_CTRL_STATUS_EN adds:
//   level       : entries held (RAM + output register)
//   almost_full : level >= ALMOST_FULL
module fifo_tp_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = DEPTH - 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              ram_cen,
    output logic                              ram_wen,
    output logic [fifo_pkg::ptr_width(DEPTH)-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0]             ram_wdata,
    output logic                              ram_ren,
    output logic [fifo_pkg::ptr_width(DEPTH)-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0]             ram_rdata
`ifdef FIFO_TP_CTRL_STATUS_EN
    ,
    output logic [fifo_pkg::level_width(DEPTH)-1:0] level,
    output logic                              almost_full
`endif
);

    localparam int ADDR_WIDTH  = ptr_width(DEPTH);
    localparam int CNT_WIDTH   = cnt_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_tp_ctrl: DEPTH must be a power of two and at least 2");
    end
    if (ALMOST_FULL < 0) begin : g_bad_af
        $error("fifo_tp_ctrl: ALMOST_FULL must not be negative");
    end

    logic [CNT_WIDTH-1:0]  r_mem_cnt;
    logic                  r_out_vld;
    logic                  w_push;
    logic                  w_fetch;
    logic [ADDR_WIDTH-1:0] w_wptr;
    logic [ADDR_WIDTH-1:0] w_rptr;

    // mem_cnt excludes words written at this edge, so a read can never hit
    // the address being written in the same cycle.
    assign s_ready = !reset && (r_mem_cnt != FULL_CNT);
    assign w_push  = s_valid && s_ready;
    assign w_fetch = !reset && (r_mem_cnt != '0) && (!r_out_vld || m_ready);

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wptr (
        .i_clk (clock),
        .i_rst (reset),
        .i_en  (w_push),
        .o_ptr (w_wptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rptr (
        .i_clk (clock),
        .i_rst (reset),
        .i_en  (w_fetch),
        .o_ptr (w_rptr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_cnt <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_mem_cnt <= r_mem_cnt + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_fetch);
            if (w_fetch) begin
                r_out_vld <= 1'b1;
            end else if (m_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign ram_wen   = w_push;
    assign ram_waddr = w_wptr;
    assign ram_wdata = s_data;
    assign ram_ren   = w_fetch;
    assign ram_raddr = w_rptr;
    assign ram_cen   = w_push | w_fetch;
    assign m_valid   = r_out_vld;
    assign m_data    = ram_rdata;

`ifdef FIFO_TP_CTRL_STATUS_EN
    localparam int LEVEL_WIDTH = level_width(DEPTH);
    localparam logic [31:0] AF_THRESH = 32'(ALMOST_FULL);

    assign level       = LEVEL_WIDTH'(r_mem_cnt) + LEVEL_WIDTH'(r_out_vld);
    assign almost_full = (32'(level) >= AF_THRESH);
`endif

endmodule
